// File: rtl/mcc_adder_sync.sv
// mcc_adder_sync: registered N-bit unsigned adder built on segmented Manchester carry chains.
// Define MCC_PIPE2_EN to register the carries and propagates ahead of the sum XOR (latency 2).

module mcc_adder_sync_seg #(
  parameter int W = 4
) (
  input  logic [W-1:0] g,
  input  logic [W-1:0] k,
  input  logic [W-1:0] p,
  input  logic         cin,
  output logic [W-1:0] c,
  output logic         gg,
  output logic         pp
);
  logic run;
  logic grun;

  // Group terms are kept apart from the cin-driven chain so they never depend on cin.
  always_comb begin
    grun = 1'b0;
    for (int i = 0; i < W; i++) grun = g[i] | (p[i] & grun);
    gg = grun;
    pp = &p;
  end

  // Manchester node: generate pulls the carry high, kill discharges it, propagate passes it on.
  always_comb begin
    run = cin;
    c   = '0;
    for (int i = 0; i < W; i++) begin
      c[i] = run;
      run  = g[i] | (~k[i] & run);
    end
  end
endmodule

module mcc_adder_sync #(
  parameter int N   = 8,
  parameter int BLK = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] sum,
  output logic           cout
);
  localparam int NSEG = (N + BLK - 1) / BLK;

  logic [N-1:0]    g, p, k, c, s;
  logic [NSEG-1:0] seg_g, seg_p, seg_c;
  logic            co, co_s, cr;

  assign g = a & b;
  assign p = a ^ b;
  assign k = ~(a | b);

  // Inter-segment ripple on group generate/propagate; seg_c is each segment's carry-in.
  always_comb begin
    cr = 1'b0;
    for (int sg = 0; sg < NSEG; sg++) begin
      seg_c[sg] = cr;
      cr        = seg_g[sg] | (seg_p[sg] & cr);
    end
    co = cr;
  end

  for (genvar sg = 0; sg < NSEG; sg++) begin : g_seg
    localparam int LO = sg * BLK;
    localparam int W  = (N - LO < BLK) ? (N - LO) : BLK;
    mcc_adder_sync_seg #(.W(W)) u_seg (
      .g   (g[LO +: W]),
      .k   (k[LO +: W]),
      .p   (p[LO +: W]),
      .cin (seg_c[sg]),
      .c   (c[LO +: W]),
      .gg  (seg_g[sg]),
      .pp  (seg_p[sg])
    );
  end

`ifdef MCC_PIPE2_EN
  typedef struct packed {
    logic [N-1:0] c;
    logic [N-1:0] p;
    logic         co;
  } mid_t;

  mid_t mid;

  always_ff @(posedge clk) begin
    if (rst) mid <= '0;
    else     mid <= '{c: c, p: p, co: co};
  end

  assign s    = mid.p ^ mid.c;
  assign co_s = mid.co;
`else
  assign s    = p ^ c;
  assign co_s = co;
`endif

  always_ff @(posedge clk) begin
    if (rst) sum <= '0;
    else     sum <= {{(N-1){1'b0}}, co_s, s};
  end

  assign cout = sum[N];
endmodule

// File: tb/tb_mcc_adder_sync.sv
// Bench for mcc_adder_sync: three widths (4, 6, 8) against a delay-line model of a+b.
module tb_mcc_adder_sync;
`ifdef MCC_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  a4, b4;
  logic [5:0]  a6, b6;
  logic [7:0]  a8, b8;
  logic [7:0]  sum4;
  logic [11:0] sum6;
  logic [15:0] sum8;
  logic        cout4, cout6, cout8;

  int errors = 0;
  int checks = 0;

  longint unsigned d4[LAT], d6[LAT], d8[LAT];
  logic [15:0] h8[$];

  always #5 clk = ~clk;

  mcc_adder_sync #(.N(4)) u4 (.clk(clk), .rst(rst), .a(a4), .b(b4), .sum(sum4), .cout(cout4));
  mcc_adder_sync #(.N(6)) u6 (.clk(clk), .rst(rst), .a(a6), .b(b6), .sum(sum6), .cout(cout6));
  mcc_adder_sync #(.N(8)) u8 (.clk(clk), .rst(rst), .a(a8), .b(b8), .sum(sum8), .cout(cout8));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: results march through a LAT-deep delay line that reset empties to zero.
  task automatic step();
    @(posedge clk);
    for (int i = LAT - 1; i > 0; i--) begin
      d4[i] = rst ? 0 : d4[i-1];
      d6[i] = rst ? 0 : d6[i-1];
      d8[i] = rst ? 0 : d8[i-1];
    end
    d4[0] = rst ? 0 : longint'(a4) + longint'(b4);
    d6[0] = rst ? 0 : longint'(a6) + longint'(b6);
    d8[0] = rst ? 0 : longint'(a8) + longint'(b8);
    #1;
    h8.push_back(sum8);
    check("sum4",  64'(sum4),  d4[LAT-1]);
    check("cout4", 64'(cout4), (d4[LAT-1] >> 4) & 1);
    check("sum6",  64'(sum6),  d6[LAT-1]);
    check("cout6", 64'(cout6), (d6[LAT-1] >> 6) & 1);
    check("sum8",  64'(sum8),  d8[LAT-1]);
    check("cout8", 64'(cout8), (d8[LAT-1] >> 8) & 1);
  endtask

  task automatic drive(input logic [3:0] x4, input logic [3:0] y4,
                       input logic [5:0] x6, input logic [5:0] y6,
                       input logic [7:0] x8, input logic [7:0] y8);
    a4 = x4; b4 = y4; a6 = x6; b6 = y6; a8 = x8; b8 = y8;
  endtask

  task automatic hold_lat();
    for (int i = 0; i < LAT; i++) step();
  endtask

  initial begin
    int t0;
    for (int i = 0; i < LAT; i++) begin d4[i] = 0; d6[i] = 0; d8[i] = 0; end

    // Reset with all-ones operands must leave outputs at zero.
    rst = 1'b1;
    drive('1, '1, '1, '1, '1, '1);
    step();
    step();
    check("rst_sum8",  64'(sum8),  64'h0);
    check("rst_cout8", 64'(cout8), 64'h0);
    check("rst_sum4",  64'(sum4),  64'h0);
    rst = 1'b0;

    // Directed vectors held for the full latency, then compared against literals.
    drive(4'b1010, 4'b1101, 6'b110110, 6'b010101, 8'hF0, 8'h55);
    hold_lat();
    check("dir_sum4",  64'(sum4),  64'h17);
    check("dir_cout4", 64'(cout4), 64'h1);
    check("dir_sum6",  64'(sum6),  64'h04B);
    check("dir_cout6", 64'(cout6), 64'h1);
    check("dir_sum8",  64'(sum8),  64'h0145);
    check("dir_cout8", 64'(cout8), 64'h1);

    // Full-length propagate chain, all-ones doubling, and zero.
    drive(4'hF, 4'h1, 6'h3F, 6'h01, 8'hFF, 8'h01);
    hold_lat();
    check("prop_sum4", 64'(sum4), 64'h10);
    check("prop_sum6", 64'(sum6), 64'h040);
    check("prop_sum8", 64'(sum8), 64'h0100);
    drive(4'hF, 4'hF, 6'h3F, 6'h3F, 8'hFF, 8'hFF);
    hold_lat();
    check("ones_sum4", 64'(sum4), 64'h1E);
    check("ones_sum6", 64'(sum6), 64'h07E);
    check("ones_sum8", 64'(sum8), 64'h01FE);
    drive('0, '0, '0, '0, '0, '0);
    hold_lat();
    check("zero_sum8",  64'(sum8),  64'h0);
    check("zero_cout8", 64'(cout8), 64'h0);

    // Back-to-back pair lands on consecutive cycles.
    t0 = h8.size();
    drive(4'h1, 4'h2, 6'h01, 6'h02, 8'h01, 8'h02);
    step();
    drive(4'h7, 4'h1, 6'h1F, 6'h01, 8'h7F, 8'h01);
    step();
    drive('0, '0, '0, '0, '0, '0);
    step();
    step();
    check("b2b_first",  64'(h8[t0 + LAT - 1]), 64'h0003);
    check("b2b_second", 64'(h8[t0 + LAT]),     64'h0080);

    // Random stream with a reset pulse dropped in to discard in-flight results.
    for (int n = 0; n < 1000; n++) begin
      drive(4'($urandom), 4'($urandom), 6'($urandom), 6'($urandom),
            8'($urandom), 8'($urandom));
      rst = (n == 500);
      step();
    end
    rst = 1'b0;
    hold_lat();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
